// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-port data-memory responder for a core-side memory
//               access unit. Accepts one request at a time, performs byte-
//               lane writes or full-word reads, and answers every request
//               with a one-cycle rvalid pulse after LATENCY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         cnt;
  logic [31:0]        resp_data;
  logic               resp_err;
  logic               rvalid;
  logic               err;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               req_err;
  logic [IDX_W-1:0]   idx;

  // Grant only from IDLE and never while reset is held
  assign gnt_o  = req_i & (state == IDLE) & ~rst_i;
  assign accept = gnt_o;
  assign idx    = addr_i[IDX_W+1:2];

  // Misaligned, out-of-range and empty-byte-enable requests are bus errors
  always_comb begin
    req_err = 1'b0;
    if (addr_i[1:0] != 2'b00)
      req_err = 1'b1;
    if ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS))
      req_err = 1'b1;
    if (be_i == 4'b0000)
      req_err = 1'b1;
  end

  // Storage: byte-lane writes at the acceptance edge; deliberately not reset
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !req_err) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n])
          mem[idx][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
  end

  // Request FSM: capture the response at acceptance, hold it through WAIT,
  // and present it for exactly one cycle in RESP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            resp_err  <= req_err;
            resp_data <= (!we_i && !req_err) ? mem[idx] : 32'd0;
            if (LATENCY == 1) begin
              state  <= RESP;
              rvalid <= 1'b1;
              err    <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= 3'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state  <= RESP;
            rvalid <= 1'b1;
            err    <= resp_err;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rvalid_o = rvalid;
  assign err_o    = err;
  assign rdata_o  = rvalid ? resp_data : 32'd0;

endmodule
`default_nettype wire
